// File: rtl/hdcfg_seq_if.sv
// Single-beat register-bus link between the configuration sequencer (master)
// and the bus engine that drives the transmitter over I2C (slave).
interface hdcfg_seq_if;
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       last;
    logic [7:0] rddata;
    logic       ack;
    logic       err;

    modport master (output req, wr, addr, wrdata, last, input rddata, ack, err);
    modport slave  (input req, wr, addr, wrdata, last, output rddata, ack, err);
endinterface

// File: rtl/hdcfg_seq.sv
// HDMI transmitter configuration sequencer: polls HPD, waits a settle time,
// then writes the {reg,val} table with per-entry retries; re-runs on HPD loss or kick.
module hdcfg_seq #(
    parameter int         NENT     = 32,
    parameter int         POLLDIV  = 100000,
    parameter int         SETTLE   = 20000000,
    parameter int         MAXRETRY = 3,
    parameter logic [7:0] HPDREG   = 8'h42,
    localparam int        IW       = $clog2(NENT)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              kick,
    output logic [IW-1:0]     tbl_idx,
    input  logic [15:0]       tbl_dat,
    hdcfg_seq_if.master       bus,
    output logic              active,
    output logic              busy,
    output logic              fail,
    output logic [7:0]        debug
);
    localparam int TMAX = (POLLDIV > SETTLE) ? POLLDIV : SETTLE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] POLL_LAST = TW'(POLLDIV - 1);
    localparam logic [TW-1:0] SETL_LAST = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_SETTLE = 3'd1,
        S_CFG    = 3'd2,
        S_DONE   = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    logic          req_q, req_d, wr_q, wr_d;
    logic [7:0]    addr_q, addr_d, wrdata_q, wrdata_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    retry_q, retry_d;
    logic          active_q, active_d, fail_q, fail_d;
    logic          kick_q, kpend_q, kpend_d;
    logic          hpd_q, hpd_d, errs_q, errs_d;
    logic          ack_v, err_v, done_v, kreq;
    logic          unused_rd;

    // err dominates ack; responses outside a transaction are dropped
    assign ack_v  = req_q & bus.ack & ~bus.err;
    assign err_v  = req_q & bus.err;
    assign done_v = ack_v | err_v;
    assign kreq   = (kick & ~kick_q) | kpend_q;

    always_comb begin
        state_d  = state_q;
        tmr_inc  = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
        tmr_d    = tmr_inc;
        req_d    = req_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        active_d = active_q;
        fail_d   = fail_q;
        kpend_d  = kpend_q;
        hpd_d    = hpd_q;
        errs_d   = errs_q | err_v;
        if (done_v)
            req_d = 1'b0;
        // a kick waits for any in-flight beat, then restarts from SETTLE
        if (kreq && (!req_q || done_v)) begin
            state_d  = S_SETTLE;
            tmr_d    = '0;
            idx_d    = '0;
            retry_d  = '0;
            fail_d   = 1'b0;
            active_d = 1'b0;
            kpend_d  = 1'b0;
        end else begin
            kpend_d = kreq;
            case (state_q)
                S_WAIT, S_DONE: begin
                    if (ack_v) begin
                        hpd_d = bus.rddata[6];
                        if (state_q == S_WAIT && bus.rddata[6]) begin
                            state_d = S_SETTLE;
                            tmr_d   = '0;
                        end else if (state_q == S_DONE && !bus.rddata[6]) begin
                            state_d  = S_WAIT;
                            active_d = 1'b0;
                            tmr_d    = '0;
                        end
                    end else if (!req_q && tmr_q >= POLL_LAST) begin
                        req_d    = 1'b1;
                        wr_d     = 1'b0;
                        addr_d   = HPDREG;
                        wrdata_d = 8'h00;
                        tmr_d    = '0;
                    end
                end
                S_SETTLE: begin
                    if (tmr_q >= SETL_LAST) begin
                        state_d = S_CFG;
                        idx_d   = '0;
                        retry_d = '0;
                    end
                end
                S_CFG: begin
                    if (ack_v) begin
                        retry_d = '0;
                        if (idx_q == IW'(NENT - 1)) begin
                            state_d  = S_DONE;
                            active_d = 1'b1;
                            fail_d   = 1'b0;
                            errs_d   = 1'b0;
                            tmr_d    = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else if (err_v) begin
                        if (retry_q == 2'(MAXRETRY)) begin
                            state_d  = S_FAIL;
                            fail_d   = 1'b1;
                            active_d = 1'b0;
                            tmr_d    = '0;
                        end else begin
                            retry_d = retry_q + 2'd1;
                        end
                    end else if (!req_q) begin
                        if (tbl_dat[15:8] == 8'hFF) begin
                            state_d  = S_DONE;
                            active_d = 1'b1;
                            fail_d   = 1'b0;
                            errs_d   = 1'b0;
                            tmr_d    = '0;
                        end else begin
                            req_d    = 1'b1;
                            wr_d     = 1'b1;
                            addr_d   = tbl_dat[15:8];
                            wrdata_d = tbl_dat[7:0];
                        end
                    end
                end
                S_FAIL: begin
                    // preload the poll timer so WAIT reads HPD right away
                    if (tmr_q >= POLL_LAST) begin
                        state_d = S_WAIT;
                        tmr_d   = POLL_LAST;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_WAIT;
            tmr_q    <= '0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 8'h00;
            wrdata_q <= 8'h00;
            idx_q    <= '0;
            retry_q  <= '0;
            active_q <= 1'b0;
            fail_q   <= 1'b0;
            kick_q   <= 1'b0;
            kpend_q  <= 1'b0;
            hpd_q    <= 1'b0;
            errs_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            active_q <= active_d;
            fail_q   <= fail_d;
            kick_q   <= kick;
            kpend_q  <= kpend_d;
            hpd_q    <= hpd_d;
            errs_q   <= errs_d;
        end
    end

    assign unused_rd  = ^{bus.rddata[7], bus.rddata[5:0]};
    assign bus.req    = req_q;
    assign bus.wr     = wr_q;
    assign bus.addr   = addr_q;
    assign bus.wrdata = wrdata_q;
    assign bus.last   = req_q;
    assign tbl_idx    = idx_q;
    assign active     = active_q;
    assign fail       = fail_q;
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CFG);
    assign debug      = {3'(state_q), retry_q, hpd_q, errs_q, req_q};
endmodule

// File: tb/tb_hdcfg_seq.sv
// Directed bench for hdcfg_seq: scripted bus responder plus one task per scenario.
module tb_hdcfg_seq;
    localparam int NENT = 8, POLLDIV = 8, SETTLE = 12;

    logic        clk, rstn, kick;
    logic [2:0]  tbl_idx;
    logic [15:0] tbl_dat;
    logic        active, busy, fail;
    logic [7:0]  debug;
    logic [15:0] rom [NENT];

    hdcfg_seq_if bif();

    hdcfg_seq #(.NENT(NENT), .POLLDIV(POLLDIV), .SETTLE(SETTLE), .MAXRETRY(3), .HPDREG(8'h42)) dut (
        .clk(clk), .rstn(rstn), .kick(kick), .tbl_idx(tbl_idx), .tbl_dat(tbl_dat),
        .bus(bif), .active(active), .busy(busy), .fail(fail), .debug(debug)
    );

    assign tbl_dat = rom[tbl_idx];

    int         npass = 0, ntot = 0, cyc = 0;
    int         wn = 0, rn = 0, rcnt = 0, werr_cnt = 0, wack_cyc = 0, rack_cyc = 0;
    logic [7:0] werr_addr = 8'h00, hpd_val = 8'h40, rd_addr = 8'h00;
    bit         resp_en = 1'b1;
    logic [7:0] wlog_a [64];
    logic [7:0] wlog_d [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", npass, ntot);
        $fatal(1);
    end

    // bus slave: answers each request on its second cycle
    initial begin
        bif.ack = 1'b0; bif.err = 1'b0; bif.rddata = 8'h00;
        forever begin
            @(negedge clk);
            if (!resp_en) rcnt = 0;
            else begin
                bif.ack = 1'b0; bif.err = 1'b0;
                if (bif.req === 1'b1) begin
                    rcnt++;
                    if (rcnt == 2) begin
                        if (bif.wr) begin
                            if (wn < 64) begin wlog_a[wn] = bif.addr; wlog_d[wn] = bif.wrdata; end
                            wn++;
                            if (werr_cnt > 0 && bif.addr == werr_addr) begin bif.err = 1'b1; werr_cnt--; end
                            else begin bif.ack = 1'b1; wack_cyc = cyc; end
                        end else begin
                            bif.rddata = hpd_val; rd_addr = bif.addr; rn++;
                            bif.ack = 1'b1; rack_cyc = cyc;
                        end
                    end
                end else rcnt = 0;
            end
        end
    end

    task automatic wait_until(input int sel, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = (busy === 1'b1);
                1: ok = (active === 1'b1);
                2: ok = (fail === 1'b1);
                3: ok = (bif.req === 1'b1 && bif.wr === 1'b0);
                4: ok = (active === 1'b0);
                5: ok = (bif.req === 1'b1 && bif.wr === 1'b1 && bif.addr === 8'h12);
                6: ok = (bif.req === 1'b1);
                7: ok = (bif.req === 1'b1 && bif.wr === 1'b1);
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
    endtask

    task automatic pulse_kick();
        kick = 1'b1;
        repeat (2) @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; kick = 1'b0;
        repeat (3) @(negedge clk);
        ntot++; if (bif.req !== 1'b0) $display("FAIL reset_req: got %b want 0", bif.req); else npass++;
        ntot++; if (active !== 1'b0 || busy !== 1'b0 || fail !== 1'b0)
            $display("FAIL reset_flags: got a/b/f %b%b%b want 000", active, busy, fail); else npass++;
        ntot++; if (debug !== 8'h00) $display("FAIL reset_debug: got %h want 00", debug); else npass++;
        ntot++; if (tbl_idx !== 3'd0 || bif.addr !== 8'h00) $display("FAIL reset_idx_addr: got %0d/%h want 0/00", tbl_idx, bif.addr); else npass++;
    endtask

    task automatic test_basic_cfg();
        bit ok; int c0;
        rstn = 1'b1;
        wait_until(0, 4 * POLLDIV, ok);
        ntot++; if (!ok) $display("FAIL basic_settle: busy never rose"); else npass++;
        ntot++; if (rd_addr !== 8'h42) $display("FAIL basic_poll_addr: got %h want 42", rd_addr); else npass++;
        c0 = cyc;
        wait_until(7, SETTLE + 10, ok);
        ntot++; if (!ok || cyc - c0 != SETTLE + 1) $display("FAIL basic_settle_len: got %0d want %0d", cyc - c0, SETTLE + 1); else npass++;
        wait_until(1, 100, ok);
        ntot++; if (!ok || cyc - wack_cyc != 2) $display("FAIL basic_active_lat: got %0d want 2", cyc - wack_cyc); else npass++;
        ntot++; if (wn != 3) $display("FAIL basic_wcount: got %0d want 3", wn); else npass++;
        for (int i = 0; i < 3; i++) begin
            ntot++; if ({wlog_a[i], wlog_d[i]} !== rom[i]) $display("FAIL basic_write%0d: got %h want %h", i, {wlog_a[i], wlog_d[i]}, rom[i]); else npass++;
        end
        ntot++; if (fail !== 1'b0 || busy !== 1'b0 || debug[7:5] !== 3'd3)
            $display("FAIL basic_done: got f/b/st %b/%b/%0d want 0/0/3", fail, busy, debug[7:5]); else npass++;
    endtask

    task automatic test_retry();
        bit ok; logic [7:0] ea [5];
        ea = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h12};
        werr_addr = 8'h11; werr_cnt = 2; wn = 0;
        pulse_kick();
        wait_until(0, 40, ok);
        wait_until(1, 200, ok);
        ntot++; if (!ok) $display("FAIL retry_active: active never rose"); else npass++;
        ntot++; if (wn != 5) $display("FAIL retry_wcount: got %0d want 5", wn); else npass++;
        for (int i = 0; i < 5; i++) begin
            ntot++; if (wlog_a[i] !== ea[i]) $display("FAIL retry_seq%0d: got %h want %h", i, wlog_a[i], ea[i]); else npass++;
        end
        ntot++; if (fail !== 1'b0 || debug[4:3] !== 2'd0) $display("FAIL retry_flags: got f/r %b/%0d want 0/0", fail, debug[4:3]); else npass++;
    endtask

    task automatic test_fail();
        bit ok; int f0;
        werr_addr = 8'h10; werr_cnt = 4; wn = 0;
        pulse_kick();
        wait_until(2, 200, ok);
        ntot++; if (!ok || active !== 1'b0 || debug[7:5] !== 3'd4)
            $display("FAIL fail_enter: got ok/a/st %b/%b/%0d want 1/0/4", ok, active, debug[7:5]); else npass++;
        ntot++; if (wn != 4 || wlog_a[3] !== 8'h10) $display("FAIL fail_wcount: got %0d want 4", wn); else npass++;
        f0 = cyc;
        wait_until(3, POLLDIV + 10, ok);
        ntot++; if (!ok || cyc - f0 != POLLDIV + 1) $display("FAIL fail_repoll: got %0d want %0d", cyc - f0, POLLDIV + 1); else npass++;
        ntot++; if (bif.addr !== 8'h42) $display("FAIL fail_poll_addr: got %h want 42", bif.addr); else npass++;
        wait_until(0, 20, ok);
        ntot++; if (!ok || fail !== 1'b1) $display("FAIL fail_sticky: got ok/f %b/%b want 1/1", ok, fail); else npass++;
        wait_until(1, 200, ok);
        ntot++; if (!ok || fail !== 1'b0 || wn != 7) $display("FAIL fail_recover: got ok/f/wn %b/%b/%0d want 1/0/7", ok, fail, wn); else npass++;
    endtask

    task automatic test_hpd_loss();
        bit ok; int w0, r0;
        hpd_val = 8'h00;
        wait_until(4, 4 * POLLDIV + 10, ok);
        ntot++; if (!ok || cyc - rack_cyc != 1) $display("FAIL hpd_drop_lat: got %0d want 1", cyc - rack_cyc); else npass++;
        ntot++; if (debug[7:5] !== 3'd0) $display("FAIL hpd_state: got %0d want 0", debug[7:5]); else npass++;
        w0 = wn; r0 = rn;
        repeat (5 * POLLDIV) @(negedge clk);
        ntot++; if (wn != w0 || busy !== 1'b0) $display("FAIL hpd_nowrite: got wn %0d busy %b want %0d 0", wn, busy, w0); else npass++;
        ntot++; if (rn - r0 < 4) $display("FAIL hpd_polls: got %0d want >=4", rn - r0); else npass++;
        hpd_val = 8'h40;
        wait_until(1, 6 * POLLDIV + SETTLE, ok);
        ntot++; if (!ok || wlog_a[w0] !== 8'h10) $display("FAIL hpd_return: got ok %b addr %h want 1 10", ok, wlog_a[w0]); else npass++;
    endtask

    task automatic test_kick_mid();
        bit ok; int wk, n;
        pulse_kick();
        wait_until(5, 200, ok);
        ntot++; if (!ok) $display("FAIL kick_find: entry 2 write not seen"); else npass++;
        kick = 1'b1; wk = wn; n = 0;
        do begin @(negedge clk); n++; end while (debug[7:5] !== 3'd1 && n < 10);
        ntot++; if (n != 2) $display("FAIL kick_settle_lat: got %0d want 2", n); else npass++;
        ntot++; if (wlog_a[wk] !== 8'h12 || tbl_idx !== 3'd0) $display("FAIL kick_complete: got %h idx %0d want 12 0", wlog_a[wk], tbl_idx); else npass++;
        kick = 1'b0;
        wait_until(1, 200, ok);
        ntot++; if (!ok || wlog_a[wk + 1] !== 8'h10 || fail !== 1'b0) $display("FAIL kick_restart: got %h want 10", wlog_a[wk + 1]); else npass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_until(6, 3 * POLLDIV, ok);
        ntot++; if (!ok) $display("FAIL rst_find: no request seen"); else npass++;
        resp_en = 1'b0; bif.ack = 1'b1; rstn = 1'b0;
        @(negedge clk);
        bif.ack = 1'b0;
        ntot++; if (bif.req !== 1'b0 || bif.wr !== 1'b0 || bif.wrdata !== 8'h00 || bif.addr !== 8'h00)
            $display("FAIL rst_bus: got req/wr/a/d %b/%b/%h/%h want 0/0/00/00", bif.req, bif.wr, bif.addr, bif.wrdata); else npass++;
        ntot++; if (debug !== 8'h00 || active !== 1'b0 || fail !== 1'b0 || tbl_idx !== 3'd0)
            $display("FAIL rst_state: got dbg %h a %b want 00 0", debug, active); else npass++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        bif.ack = 1'b1; bif.rddata = 8'h40;
        @(negedge clk);
        bif.ack = 1'b0;
        @(negedge clk);
        ntot++; if (debug !== 8'h00 || busy !== 1'b0) $display("FAIL rst_stray_ack: got dbg %h busy %b want 00 0", debug, busy); else npass++;
        resp_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) rom[i] = 16'hFF00;
        rom[0] = 16'h10A1; rom[1] = 16'h11B2; rom[2] = 16'h12C3;
        test_reset();
        test_basic_cfg();
        test_retry();
        test_fail();
        test_hpd_loss();
        test_kick_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
